clock_div2: RTL and testbench

// - Divides the input clock frequency by two and produces a 50% duty-cycle output, clk_out.
// - clk_out is a register that toggles on every rising edge of clk, so it has half the frequency of clk.
// - It is a leaf block. It feeds logic that needs a half-rate clock or a half-rate enable that is

---
 rtl/clock_div2.sv | 33 +++
 tb/tb_clock_div2.sv | 104 ++++++++++
 2 files changed

// File: rtl/clock_div2.sv
// Divide-by-two clock generator.
// A single flop toggles on every rising edge of clk, so clk_out has half the
// frequency of clk and an exact 50% duty cycle. clk_out is taken straight from
// the flop, so it is glitch-free and is never a gated copy of clk.
module clock_div2 #(
   // Keep at 0: downstream timing assumes clk_out is low after reset.
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   output logic clk_out
);

   logic q_q;
   logic q_d;

   // Next state: invert the current phase every cycle.
   always_comb begin
      q_d = ~q_q;
   end

   // Phase register; rst is only seen at a rising edge and wins over the toggle.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign clk_out = q_q;

endmodule

// File: tb/tb_clock_div2.sv
// Self-checking bench for clock_div2.
// Expected clk_out values are pushed to a scoreboard queue as each rising edge
// is driven, then popped and compared once the DUT has updated.
`timescale 1ns / 100ps
module tb_clock_div2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clk_out;

   logic exp_q[$];
   logic model_q;
   int   checks = 0;
   int   errors = 0;

   clock_div2 dut (
      .clk     (clk),
      .rst     (rst),
      .clk_out (clk_out)
   );

   // 10 ns clock period.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive rst for one rising edge, push the expected output, then compare it.
   task automatic step(input logic r, input string tag);
      rst = r;
      @(posedge clk);
      model_q = r ? 1'b0 : ~model_q;
      exp_q.push_back(model_q);
      #1;
      check_eq(tag, {31'b0, clk_out}, {31'b0, exp_q.pop_front()});
      @(negedge clk);
   endtask

   // Hard stop in case anything stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      realtime edges[$];
      logic    prev;
      model_q = 1'bx;

      // Reset hold: clk_out low after each of 3 reset edges.
      for (int i = 0; i < 3; i++) step(1'b1, "reset_hold");

      // Release: rst drops between edges; output toggles 1,0,1,... after each edge.
      for (int i = 0; i < 20; i++) step(1'b0, "release");

      // Period and duty: record clk_out transitions over 11+ periods.
      #0.5;
      prev = clk_out;
      for (int i = 0; i < 230; i++) begin
         #1;
         if (clk_out !== prev) edges.push_back($realtime);
         prev = clk_out;
      end
      check_eq("edge_count_ok", {31'b0, edges.size() >= 21}, 32'd1);
      for (int i = 1; i < edges.size(); i++) begin
         check_eq("half_period_ns", int'(edges[i] - edges[i-1]), 32'd10);
      end
      for (int i = 2; i < edges.size(); i += 2) begin
         check_eq("period_ns", int'(edges[i] - edges[i-2]), 32'd20);
      end
      @(negedge clk);

      // Resynchronise the model with a reset edge.
      step(1'b1, "resync_reset");

      // Mid-run reset while high.
      step(1'b0, "pre_hi");
      step(1'b1, "rst_while_hi");
      step(1'b0, "resume_after_hi");

      // Mid-run reset while low.
      step(1'b0, "pre_lo");
      step(1'b1, "rst_while_lo");
      step(1'b0, "resume_after_lo");

      // Synchronous check: rst asserted mid-cycle must not affect clk_out yet.
      #2 rst = 1'b1;
      #1 check_eq("sync_hold", {31'b0, clk_out}, 32'd1);
      #1 check_eq("sync_hold_late", {31'b0, clk_out}, 32'd1);
      step(1'b1, "sync_edge");
      step(1'b0, "sync_resume");
      step(1'b0, "sync_resume2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
